// File: rtl/branch_history_queue_pkg.sv
// Shared types for the global-history predictor and its branch history queue.
package branch_history_queue_pkg;

  typedef logic [31:0] Vaddr;
  typedef logic [5:0]  GlobalHistoryReg;
  typedef logic [1:0]  TwoBitState;

  // Per-branch snapshot produced by the predictor at predict time.
  typedef struct packed {
    GlobalHistoryReg GHR;
    GlobalHistoryReg Recover_GHR;
    TwoBitState      Predict_Counter;
  } Predict_GHR_S;

  // Training / recovery record sent back to the predictor at resolution.
  typedef struct packed {
    logic            PC_Vaild;
    logic            PC_MissPredict;
    Vaddr            Update_PC;
    GlobalHistoryReg GHR;
    GlobalHistoryReg Recover_GHR;
    TwoBitState      Counter;
    logic            PC_Taken;
  } Update_GHR_S;

  localparam int BHQ_DEPTH = 8;

  // One in-flight branch held in the queue.
  typedef struct packed {
    Vaddr            pc;
    GlobalHistoryReg ghr;
    GlobalHistoryReg recover_ghr;
    TwoBitState      counter;
  } bhq_entry_t;

  // The recovery GHR holds the opposite of the predicted direction in bit 0,
  // so the prediction itself never needs its own storage bit.
  function automatic logic bhq_pred_taken(input GlobalHistoryReg recover_ghr);
    return ~recover_ghr[0];
  endfunction

endpackage

// File: rtl/branch_history_queue_bhq_ram.sv
// Entry storage for the branch history queue: one write port, one
// asynchronous read port, no reset on the array contents.
module bhq_ram
  import branch_history_queue_pkg::*;
#(
  parameter  int DEPTH = BHQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  bhq_entry_t       wdata,
  input  logic [PTR_W-1:0] raddr,
  output bhq_entry_t       rdata
);

  bhq_entry_t mem [DEPTH];

  // Write the enqueued entry at the tail slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_history_queue.sv
// In-order queue of global-history snapshots between predict and resolve.
// Produces the registered Update_GHR record that trains the PHT and, on a
// mispredict, lets the predictor restore its GHR.
module branch_history_queue
  import branch_history_queue_pkg::*;
#(
  parameter int DEPTH = BHQ_DEPTH
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enq_valid,
  input  Vaddr         enq_pc,
  input  Predict_GHR_S enq_info,
  input  logic         resolve_valid,
  input  logic         resolve_taken,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output Update_GHR_S  Update_GHR,
  output logic         err_overflow,
  output logic         err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  Update_GHR_S      update_ghr_q, update_ghr_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_underflow_q, err_underflow_d;

  logic       do_enq;
  logic       do_res;
  logic       mispredict;
  logic       kill;
  bhq_entry_t wr_entry;
  bhq_entry_t head_entry;

  // Status comes straight from the registered count, never from inputs.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  assign Update_GHR    = update_ghr_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

  bhq_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (do_enq),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (head_entry)
  );

  // Decide which operations take effect this cycle; a flush or a mispredict
  // kills the queue and with it any same-cycle enqueue.
  always_comb begin
    do_res     = resolve_valid && !empty && !flush;
    mispredict = do_res && (resolve_taken != bhq_pred_taken(head_entry.recover_ghr));
    kill       = flush || mispredict;
    do_enq     = enq_valid && !full && !kill;

    wr_entry             = '0;
    wr_entry.pc          = enq_pc;
    wr_entry.ghr         = enq_info.GHR;
    wr_entry.recover_ghr = enq_info.Recover_GHR;
    wr_entry.counter     = enq_info.Predict_Counter;
  end

  // Next pointers and occupancy; a kill collapses head onto tail.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (kill) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_enq) begin
        tail_d = tail_q + 1'b1;
      end
      if (do_res) begin
        head_d = head_q + 1'b1;
      end
      case ({do_enq, do_res})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Build the next training record from the popped head entry.
  always_comb begin
    update_ghr_d = '0;
    if (do_res) begin
      update_ghr_d.PC_Vaild       = 1'b1;
      update_ghr_d.PC_MissPredict = mispredict;
      update_ghr_d.Update_PC      = head_entry.pc;
      update_ghr_d.GHR            = head_entry.ghr;
      update_ghr_d.Recover_GHR    = head_entry.recover_ghr;
      update_ghr_d.Counter        = head_entry.counter;
      update_ghr_d.PC_Taken       = resolve_taken;
    end
  end

  // Sticky protocol-violation flags, cleared only by reset.
  always_comb begin
    err_overflow_d  = err_overflow_q  || (enq_valid && full);
    err_underflow_d = err_underflow_q || (resolve_valid && empty);
  end

  // All control state and the output record; entry storage is not reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      update_ghr_q    <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      update_ghr_q    <= update_ghr_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

endmodule

// File: tb/tb_branch_history_queue.sv
// Self-checking bench for branch_history_queue with a queue-based model.
module tb_branch_history_queue;
  import branch_history_queue_pkg::*;

  localparam int DEPTH = BHQ_DEPTH;

  logic         clk = 1'b0;
  logic         resetn;
  logic         enq_valid;
  Vaddr         enq_pc;
  Predict_GHR_S enq_info;
  logic         resolve_valid;
  logic         resolve_taken;
  logic         flush;
  logic         full;
  logic         empty;
  Update_GHR_S  update_ghr;
  logic         err_overflow;
  logic         err_underflow;

  int checks = 0;
  int errors = 0;

  bhq_entry_t  mq[$];
  Update_GHR_S exp_upd;
  logic        exp_ovf;
  logic        exp_unf;

  branch_history_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enq_valid     (enq_valid),
    .enq_pc        (enq_pc),
    .enq_info      (enq_info),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .full          (full),
    .empty         (empty),
    .Update_GHR    (update_ghr),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic Predict_GHR_S mk_info(input logic [5:0] g, input logic [5:0] rg,
                                           input logic [1:0] c);
    Predict_GHR_S p;
    p.GHR = g;
    p.Recover_GHR = rg;
    p.Predict_Counter = c;
    return p;
  endfunction

  function automatic Predict_GHR_S rand_info();
    return mk_info(6'($urandom), 6'($urandom), 2'($urandom));
  endfunction

  // Reference model: a FIFO of entries with the queue rules applied directly.
  function automatic void model_reset();
    mq.delete();
    exp_upd = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endfunction

  function automatic void model_step(input logic ev, input Vaddr pc, input Predict_GHR_S info,
                                     input logic rv, input logic tk, input logic fl);
    bhq_entry_t e;
    logic was_full, was_empty, wrong;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    wrong     = 1'b0;
    exp_upd   = '0;
    if (rv && !was_empty && !fl) begin
      e = mq.pop_front();
      wrong = (tk != (e.recover_ghr[0] == 1'b0));
      exp_upd.PC_Vaild       = 1'b1;
      exp_upd.PC_MissPredict = wrong;
      exp_upd.Update_PC      = e.pc;
      exp_upd.GHR            = e.ghr;
      exp_upd.Recover_GHR    = e.recover_ghr;
      exp_upd.Counter        = e.counter;
      exp_upd.PC_Taken       = tk;
    end
    if (ev && was_full) exp_ovf = 1'b1;
    if (rv && was_empty) exp_unf = 1'b1;
    if (fl || wrong) begin
      mq.delete();
    end else if (ev && !was_full) begin
      e.pc = pc;
      e.ghr = info.GHR;
      e.recover_ghr = info.Recover_GHR;
      e.counter = info.Predict_Counter;
      mq.push_back(e);
    end
  endfunction

  // Drive one cycle of inputs, advance the model, and land 1 ns past the edge.
  task automatic drive_cycle(input logic ev, input Vaddr pc, input Predict_GHR_S info,
                             input logic rv, input logic tk, input logic fl);
    enq_valid = ev;
    enq_pc = pc;
    enq_info = info;
    resolve_valid = rv;
    resolve_taken = tk;
    flush = fl;
    model_step(ev, pc, info, rv, tk, fl);
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enq_valid = 1'b0;
    enq_pc = '0;
    enq_info = '0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush = 1'b0;
    model_reset();
    #3;
    checks++;
    if (update_ghr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_update: got %h, expected 0", update_ghr);
    end
    checks++;
    if ({full, empty, err_overflow, err_underflow} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL reset_status: got %b, expected 0100",
               {full, empty, err_overflow, err_underflow});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    Update_GHR_S want;
    want.PC_Vaild = 1'b1;
    want.PC_MissPredict = 1'b0;
    want.Update_PC = 32'h1000;
    want.GHR = 6'b000011;
    want.Recover_GHR = 6'b000110;
    want.Counter = 2'b10;
    want.PC_Taken = 1'b1;
    drive_cycle(1'b1, 32'h1000, mk_info(6'b000011, 6'b000110, 2'b10), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (update_ghr !== want) begin
      errors++;
      $display("[TB] FAIL basic_update: got %h, expected %h", update_ghr, want);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_empty: got %b, expected 1", empty);
    end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (update_ghr.PC_Vaild !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_pulse: got %b, expected 0", update_ghr.PC_Vaild);
    end
  endtask

  task automatic test_mispredict();
    logic [5:0] rg0;
    rg0 = {5'($urandom), 1'b0};
    drive_cycle(1'b1, 32'h2000, mk_info(6'h15, rg0, 2'b11), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h2004, rand_info(), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h2008, rand_info(), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (update_ghr !== exp_upd) begin
      errors++;
      $display("[TB] FAIL mispredict_update: got %h, expected %h", update_ghr, exp_upd);
    end
    checks++;
    if ({update_ghr.PC_MissPredict, update_ghr.Recover_GHR} !== {1'b1, rg0}) begin
      errors++;
      $display("[TB] FAIL mispredict_flag: got %b/%b, expected 1/%b",
               update_ghr.PC_MissPredict, update_ghr.Recover_GHR, rg0);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mispredict_empty: got %b, expected 1", empty);
    end
  endtask

  task automatic test_full_wrap();
    Vaddr pcs[DEPTH];
    logic pred[DEPTH];
    Predict_GHR_S inf;
    for (int i = 0; i < DEPTH; i++) begin
      pcs[i] = $urandom;
      inf = rand_info();
      pred[i] = ~inf.Recover_GHR[0];
      drive_cycle(1'b1, pcs[i], inf, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_flag: got %b, expected 1", full);
    end
    drive_cycle(1'b1, 32'hDEAD_BEE0, rand_info(), 1'b0, 1'b0, 1'b0);
    checks++;
    if ({err_overflow, full} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL overflow_flag: got %b, expected 11", {err_overflow, full});
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, pred[i], 1'b0);
      checks++;
      if (update_ghr.Update_PC !== pcs[i] || update_ghr !== exp_upd) begin
        errors++;
        $display("[TB] FAIL wrap_order[%0d]: got %h, expected pc %h rec %h",
                 i, update_ghr, pcs[i], exp_upd);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_empty: got %b, expected 1", empty);
    end
  endtask

  task automatic test_underflow();
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({update_ghr.PC_Vaild, err_underflow} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL underflow: got valid/err %b, expected 01",
               {update_ghr.PC_Vaild, err_underflow});
    end
  endtask

  task automatic test_back_to_back();
    Vaddr pcs[4];
    logic pred[4];
    Vaddr new_pc;
    Predict_GHR_S inf;
    for (int i = 0; i < 4; i++) begin
      pcs[i] = $urandom;
      inf = rand_info();
      pred[i] = ~inf.Recover_GHR[0];
      drive_cycle(1'b1, pcs[i], inf, 1'b0, 1'b0, 1'b0);
    end
    new_pc = 32'h0000_B2B0;
    drive_cycle(1'b1, new_pc, rand_info(), 1'b1, pred[0], 1'b0);
    checks++;
    if ({full, empty, update_ghr.PC_Vaild} !== 3'b001 || update_ghr.Update_PC !== pcs[0]) begin
      errors++;
      $display("[TB] FAIL b2b_first: got fe %b%b pc %h, expected 00 pc %h",
               full, empty, update_ghr.Update_PC, pcs[0]);
    end
    for (int i = 1; i < 4; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, pred[i], 1'b0);
    end
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_count: got empty %b, expected 0", empty);
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (update_ghr.Update_PC !== new_pc || empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_last: got pc %h empty %b, expected pc %h empty 1",
               update_ghr.Update_PC, empty, new_pc);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, $urandom, rand_info(), 1'b0, 1'b0, 1'b0);
    end
    drive_cycle(1'b1, $urandom, rand_info(), 1'b1, 1'b1, 1'b1);
    checks++;
    if ({update_ghr.PC_Vaild, empty} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL flush: got valid/empty %b, expected 01", {update_ghr.PC_Vaild, empty});
    end
  endtask

  task automatic test_random();
    logic ev, rv, tk, fl;
    for (int n = 0; n < 400; n++) begin
      ev = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      if (mq.size() > 0) begin
        tk = (mq[0].recover_ghr[0] == 1'b0);
        if ($urandom_range(0, 9) == 0) tk = ~tk;
      end else begin
        tk = 1'($urandom);
      end
      drive_cycle(ev, $urandom, rand_info(), rv, tk, fl);
      checks++;
      if (update_ghr !== exp_upd) begin
        errors++;
        $display("[TB] FAIL rand_update[%0d]: got %h, expected %h", n, update_ghr, exp_upd);
      end
      checks++;
      if ({full, empty} !== {mq.size() == DEPTH, mq.size() == 0}) begin
        errors++;
        $display("[TB] FAIL rand_status[%0d]: got %b%b, expected size %0d", n, full, empty, mq.size());
      end
      checks++;
      if ({err_overflow, err_underflow} !== {exp_ovf, exp_unf}) begin
        errors++;
        $display("[TB] FAIL rand_errs[%0d]: got %b%b, expected %b%b",
                 n, err_overflow, err_underflow, exp_ovf, exp_unf);
      end
    end
  endtask

  task automatic test_reset_midstream();
    Predict_GHR_S inf;
    inf = rand_info();
    if (mq.size() == DEPTH) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h0000_5550, inf, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0000_5554, rand_info(), 1'b1, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (update_ghr !== '0 || {full, empty, err_overflow, err_underflow} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL midreset: got upd %h status %b, expected 0 / 0100",
               update_ghr, {full, empty, err_overflow, err_underflow});
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({update_ghr.PC_Vaild, err_underflow} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midreset_discard: got %b, expected 01",
               {update_ghr.PC_Vaild, err_underflow});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mispredict();
    test_full_wrap();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
